// File: rtl/vga_tile_grid.sv
// VGA timing generator and GRID x GRID tile-puzzle renderer fed from one source image in an external ROM.
// The tile map and cursor are sampled once per frame, so on-screen updates never tear.
module vga_tile_grid #(
    parameter int          GRID       = 2,
    parameter int          TILE       = 240,
    parameter int          IDX_W      = 3,
    parameter int          ADDR_W     = 18,
    parameter int          CLK_DIV    = 4,
    parameter int          X_OFF      = 0,
    parameter int          Y_OFF      = 0,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          BLANK_IDX  = 7,
    parameter logic [11:0] BLANK_RGB  = 12'h000,
    parameter int          CURSOR_W   = 4,
    parameter logic [11:0] CURSOR_RGB = 12'hF00
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic [GRID*GRID*IDX_W-1:0]  tile_map,
    input  logic [IDX_W-1:0]            cursor_cell,
    input  logic                        cursor_en,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [11:0]                 rom_data,
    output logic [3:0]                  red,
    output logic [3:0]                  green,
    output logic [3:0]                  blue,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CELLS   = GRID * GRID;
    localparam int SPAN    = GRID * TILE;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int D_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int T_W     = $clog2(TILE);
    localparam int C_W     = $clog2(GRID + 1);

    localparam logic [D_W-1:0] DIV_LAST = D_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_LO    = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_HI    = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] VS_LO    = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_HI    = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [H_W-1:0] X_LO     = H_W'(X_OFF);
    localparam logic [V_W-1:0] Y_LO     = V_W'(Y_OFF);
    localparam logic [H_W-1:0] X_SPAN   = H_W'(SPAN);
    localparam logic [V_W-1:0] Y_SPAN   = V_W'(SPAN);
    localparam logic [T_W-1:0] T_LAST   = T_W'(TILE - 1);
    localparam logic [T_W-1:0] CW_LO    = T_W'(CURSOR_W);
    localparam logic [T_W-1:0] CW_HI    = T_W'(TILE - CURSOR_W);

    logic [D_W-1:0]   div_cnt;
    logic [H_W-1:0]   h, h_nxt, hx;
    logic [V_W-1:0]   v, v_nxt, vy;
    logic [T_W-1:0]   ox, oy;
    logic [C_W-1:0]   cc, cr;
    logic             pix_ce, h_last, v_last, frame_edge;

    logic [IDX_W-1:0] shadow [CELLS];
    logic [IDX_W-1:0] cursor_cell_sh;
    logic             cursor_en_sh;

    logic             active_c, in_grid_c, hs_c, vs_c, blank_c, border_c, cursor_c;
    logic [15:0]      cell_num, kr, kc;
    logic [IDX_W-1:0] k;
    logic [31:0]      addr_full;

    logic             s1_active, s1_grid, s1_blank, s1_cursor, s1_hs, s1_vs;

    assign pix_ce     = (div_cnt == DIV_LAST);
    assign h_last     = (h == H_LAST);
    assign v_last     = (v == V_LAST);
    assign frame_edge = pix_ce && h_last && v_last;
    assign h_nxt      = h_last ? '0 : h + 1'b1;
    assign v_nxt      = h_last ? (v_last ? '0 : v + 1'b1) : v;

    // Raster counters plus running cell/offset counters that restart at the grid's left and top edges.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            div_cnt     <= '0;
            h           <= '0;
            v           <= '0;
            ox          <= '0;
            oy          <= '0;
            cc          <= '0;
            cr          <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_edge;
            div_cnt     <= pix_ce ? '0 : div_cnt + 1'b1;
            if (pix_ce) begin
                h <= h_nxt;
                v <= v_nxt;
                if (h_nxt == X_LO) begin
                    ox <= '0;
                    cc <= '0;
                end else if (ox == T_LAST) begin
                    ox <= '0;
                    cc <= cc + 1'b1;
                end else begin
                    ox <= ox + 1'b1;
                end
                if (h_last) begin
                    if (v_nxt == Y_LO) begin
                        oy <= '0;
                        cr <= '0;
                    end else if (oy == T_LAST) begin
                        oy <= '0;
                        cr <= cr + 1'b1;
                    end else begin
                        oy <= oy + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CELLS; c++) shadow[c] <= IDX_W'(c);
            cursor_cell_sh <= '0;
            cursor_en_sh   <= 1'b0;
        end else if (frame_edge) begin
            for (int c = 0; c < CELLS; c++) shadow[c] <= tile_map[c*IDX_W +: IDX_W];
            cursor_cell_sh <= cursor_cell;
            cursor_en_sh   <= cursor_en;
        end
    end

    // Unsigned wrap of h-X_OFF makes left-of-grid pixels compare as huge, so one bound check suffices.
    always_comb begin
        hx        = h - X_LO;
        vy        = v - Y_LO;
        active_c  = (h < H_ACT) && (v < V_ACT);
        in_grid_c = active_c && (hx < X_SPAN) && (vy < Y_SPAN);
        hs_c      = !((h >= HS_LO) && (h < HS_HI));
        vs_c      = !((v >= VS_LO) && (v < VS_HI));

        cell_num = 16'(cr) * 16'(GRID) + 16'(cc);
        k = '0;
        for (int c = 0; c < CELLS; c++)
            if (cell_num == 16'(c)) k = shadow[c];

        kr      = '0;
        kc      = '0;
        blank_c = 1'b1;
        for (int t = 0; t < CELLS; t++) begin
            if (k == IDX_W'(t)) begin
                kr      = 16'(t / GRID);
                kc      = 16'(t % GRID);
                blank_c = (t == BLANK_IDX);
            end
        end

        addr_full = (32'(kr) * 32'(TILE) + 32'(oy)) * 32'(SPAN) + 32'(kc) * 32'(TILE) + 32'(ox);
        border_c  = (ox < CW_LO) || (ox >= CW_HI) || (oy < CW_LO) || (oy >= CW_HI);
        cursor_c  = cursor_en_sh && (cell_num == 16'(cursor_cell_sh)) && border_c;
    end

    // Stage 1 issues the ROM address; stage 2 picks the colour once ROM data for that pixel is back.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            rom_addr  <= '0;
            s1_active <= 1'b0;
            s1_grid   <= 1'b0;
            s1_blank  <= 1'b0;
            s1_cursor <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else if (pix_ce) begin
            s1_active <= active_c;
            s1_grid   <= in_grid_c;
            s1_blank  <= blank_c;
            s1_cursor <= in_grid_c && cursor_c;
            s1_hs     <= hs_c;
            s1_vs     <= vs_c;
            if (in_grid_c && !blank_c) rom_addr <= ADDR_W'(addr_full);

            hsync <= s1_hs;
            vsync <= s1_vs;
            if (!s1_active || !s1_grid)
                {red, green, blue} <= 12'h000;
            else if (s1_cursor)
                {red, green, blue} <= CURSOR_RGB;
            else if (s1_blank)
                {red, green, blue} <= BLANK_RGB;
            else
                {red, green, blue} <= rom_data;
        end
    end

endmodule

// File: doc/vga_tile_grid.md
Name: vga_tile_grid

Overview:
- Parametrised successor to the fixed 2x2 quadrant VGA renderer.
- Generates VGA timing internally and renders a GRID x GRID tile puzzle from one source image held in an external synchronous ROM.
- Each screen cell shows any source tile selected by a per-cell index, or a blank colour.
- Adds a per-frame shadow map (tear-free updates), a cursor border overlay and ROM-latency-aligned sync outputs.

Parameters:
- GRID, 2, cells per side.
- TILE, 240, tile side in pixels.
- IDX_W, 3, bits per cell index.
- ADDR_W, 18, ROM address width.
- CLK_DIV, 4, sys_clk cycles per pixel.
- X_OFF, 0, grid left edge in active pixels.
- Y_OFF, 0, grid top edge in active lines.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.
- BLANK_IDX, 7, index rendered as a blank cell.
- BLANK_RGB, 12'h000, blank-cell colour.
- CURSOR_W, 4, cursor border thickness in pixels.
- CURSOR_RGB, 12'hF00, cursor colour.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tile_map  in  GRID*GRID*IDX_W  cell c index at bits [c*IDX_W +: IDX_W]; c = row*GRID + col.
- cursor_cell  in  IDX_W  cell number to outline.
- cursor_en  in  1  cursor overlay enable.
- rom_addr  out  ADDR_W  source pixel address.
- rom_data  in  12  {R,G,B} from ROM; valid one pix_ce after the address is presented.
- red/green/blue  out  4 each  pixel colour.
- hsync, vsync  out  1 each  active-low sync.
- frame_start  out  1  one-sys_clk pulse per frame.

Behaviour:
- Reset (rst=0, asynchronous): rgb=0, hsync=vsync=1, frame_start=0, rom_addr=0, counters=0, div_cnt=0, pipeline cleared. Shadow map resets to identity (cell c holds tile c); shadow cursor disabled.
- Pixel strobe: div_cnt counts 0..CLK_DIV-1; pix_ce=1 when div_cnt==CLK_DIV-1. All pixel logic advances only on pix_ce.
- Horizontal counter: h runs 0..H_TOTAL-1. Active region is h<H_ACTIVE. Sync window is [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- Vertical counter: v increments when h wraps; same active/sync layout as horizontal.
- Frame boundary: on the pix_ce where the counters become (0,0), frame_start pulses and tile_map, cursor_cell and cursor_en are latched into the shadow registers. Input changes mid-frame have no effect until the next frame.
- Stage 1 (registered): local x=h-X_OFF, y=v-Y_OFF. The pixel is in the grid iff active and 0<=x<GRID*TILE and 0<=y<GRID*TILE.
  - Cell: cc=x/TILE, cr=y/TILE; offsets ox=x%TILE, oy=y%TILE. Implement with per-cell running offset counters, not dividers.
  - Index k=shadow[cr*GRID+cc], with kr=k/GRID and kc=k%GRID.
  - rom_addr=(kr*TILE+oy)*(GRID*TILE)+kc*TILE+ox, truncated to ADDR_W.
  - When k==BLANK_IDX or k>=GRID*GRID, the cell is blank and rom_addr holds its previous value.
  - Outside the grid, rom_addr is unchanged.
- Stage 2: pixel colour is selected in this priority order:
  1. Not active, or outside the grid: 0.
  2. Cursor enabled, cell==cursor_cell, and ox<CURSOR_W or ox>=TILE-CURSOR_W or oy<CURSOR_W or oy>=TILE-CURSOR_W: CURSOR_RGB.
  3. Blank cell: BLANK_RGB.
  4. Otherwise: rom_data.
- Alignment: hsync, vsync, active and the cell flags are delayed 2 pix_ce, so rgb and sync leave aligned. Total latency is 2 pix_ce from counter to pins.
- cursor_cell>=GRID*GRID: no border is drawn.

Test Plan:
- Reset: hold rst=0 mid-frame, release. Required: rgb=0 and hsync=vsync=1 during reset; first frame_start exactly H_TOTAL*V_TOTAL*CLK_DIV=1,680,000 sys_clk after release (defaults).
- Timing: count pix_ce. Required: hsync low for 96 of every 800 pixels, starting 658 pixels after h=0; vsync low for 2 lines starting at line 490; frame_start period 420,000 pix_ce.
- Identity map (defaults): at h=245, v=3, required rom_addr=1685. After a frame_start with tile_map cell0=3, at h=0, v=0, required rom_addr=115440 and rgb=rom_data 2 pix_ce later.
- Tear-free update: change tile_map at line 100. Required: addresses unchanged until the next frame_start, then the new map takes effect.
- Blank and out-of-range: cell1=7 → BLANK_RGB over x 240..479; cell2=5 (>=4) → BLANK_RGB. Pixels at h>=480 → rgb=0.
- Cursor: cursor_en=1, cursor_cell=3. Required: CURSOR_RGB at (240..243, 240..479) and at (476..479, any y in cell 3); interior pixels show ROM data; cursor_cell=4 draws no border.
